// File: rtl/led_pkg.sv
// Shared timing constants for the LED blinker and its PWM fade stage.
package led_pkg;

  localparam int PWM_BITS_DEF = 8;
  // 256 duty steps of STEP_DIV_DEF cycles make roughly one second at 100 MHz.
  localparam int STEP_DIV_DEF = 390_625;
  localparam int BLINK_PERIOD = 50_000_000;

  function automatic int duty_max(input int bits);
    return (1 << bits) - 1;
  endfunction

endpackage

// File: rtl/led_pwm_gen.sv
// Free-running PWM counter with a registered duty comparator.
// Define LED_PWM_GAMMA_EN to compare against a squared (gamma-corrected) duty.
module led_pwm_gen
  import led_pkg::*;
#(
  parameter int PWM_BITS = PWM_BITS_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PWM_BITS-1:0] duty,
  input  logic                enable,
  output logic                pwm_out
);

  localparam logic [PWM_BITS-1:0] DMAX = PWM_BITS'(duty_max(PWM_BITS));

  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] cmp;

`ifdef LED_PWM_GAMMA_EN
  logic [2*PWM_BITS-1:0] prod;

  // Full scale is pinned so the top duty still means constant-on.
  always_comb begin
    prod = (2*PWM_BITS)'(duty) * (2*PWM_BITS)'(duty);
    cmp  = (duty == DMAX) ? DMAX : prod[2*PWM_BITS-1:PWM_BITS];
  end
`else
  assign cmp = duty;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pwm_cnt <= '0;
      pwm_out <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      pwm_out <= enable && ((cmp == DMAX) || (pwm_cnt < cmp));
    end
  end

endmodule

// File: rtl/led_pwm_fade.sv
// Linear LED fade: ramps duty one LSB every STEP_DIV cycles toward the led_in
// level and drives the pin through led_pwm_gen (gamma option: LED_PWM_GAMMA_EN).
module led_pwm_fade
  import led_pkg::*;
#(
  parameter int PWM_BITS = PWM_BITS_DEF,
  parameter int STEP_DIV = STEP_DIV_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                led_in,
  input  logic                enable,
  output logic                pwm_out,
  output logic [PWM_BITS-1:0] duty,
  output logic                fading
);

  localparam int                  PRE_W    = $clog2(STEP_DIV);
  localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(STEP_DIV - 1);
  localparam logic [PWM_BITS-1:0] DMAX     = PWM_BITS'(duty_max(PWM_BITS));

  logic             led_q;
  logic [PRE_W-1:0] prescaler;
  logic             change;

  assign change = led_in ^ led_q;

  // A level change restarts the step interval; it takes priority over a tick
  // so the new direction always gets a full STEP_DIV before its first step.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led_q     <= 1'b0;
      prescaler <= '0;
      duty      <= '0;
    end else begin
      led_q <= led_in;
      if (!enable) begin
        prescaler <= '0;
        duty      <= '0;
      end else if (change) begin
        prescaler <= '0;
      end else if (prescaler == PRE_LAST) begin
        prescaler <= '0;
        if (led_q && duty != DMAX)
          duty <= duty + PWM_BITS'(1);
        else if (!led_q && duty != '0)
          duty <= duty - PWM_BITS'(1);
      end else begin
        prescaler <= prescaler + PRE_W'(1);
      end
    end
  end

  assign fading = enable && (led_q ? (duty != DMAX) : (duty != '0));

  led_pwm_gen #(
    .PWM_BITS(PWM_BITS)
  ) u_pwm_gen (
    .clk    (clk),
    .rst    (rst),
    .duty   (duty),
    .enable (enable),
    .pwm_out(pwm_out)
  );

endmodule

// File: tb/tb_led_pwm_fade.sv
// Scoreboard bench for led_pwm_fade: stimulus queues expectations, a monitor
// pops and compares them against the live DUT outputs.
module tb_led_pwm_fade;

  localparam int PB = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic led_in = 1'b0, enable = 1'b0;
  logic led_in_s = 1'b0, enable_s = 1'b0;
  logic pwm_out, fading, pwm_s, fading_s;
  logic [PB-1:0] duty, duty_s;

  always #5 clk = ~clk;

  led_pwm_fade #(.PWM_BITS(PB), .STEP_DIV(4)) dut (
    .clk(clk), .rst(rst), .led_in(led_in), .enable(enable),
    .pwm_out(pwm_out), .duty(duty), .fading(fading)
  );

  led_pwm_fade #(.PWM_BITS(PB), .STEP_DIV(1000)) dut_slow (
    .clk(clk), .rst(rst), .led_in(led_in_s), .enable(enable_s),
    .pwm_out(pwm_s), .duty(duty_s), .fading(fading_s)
  );

  localparam int SEL_DUTY = 0, SEL_FADING = 1, SEL_PWM = 2, SEL_DUTY_S = 3, SEL_HI = 4;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  event chk_ev;
  int   pending = 0;
  int   total = 0;
  int   bad = 0;
  int   hi_cnt = 0;

  function automatic logic [31:0] actual(int sel);
    case (sel)
      SEL_DUTY:   return 32'(duty);
      SEL_FADING: return 32'(fading);
      SEL_PWM:    return 32'(pwm_out);
      SEL_DUTY_S: return 32'(duty_s);
      SEL_HI:     return 32'(hi_cnt);
      default:    return 32'hffff_ffff;
    endcase
  endfunction

  function automatic int exp_hi(int d);
`ifdef LED_PWM_GAMMA_EN
    return (d == 15) ? 16 : (d * d) / 16;
`else
    return (d == 15) ? 16 : d;
`endif
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(chk_ev);
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check(e.name, actual(e.sel), e.exp);
        pending--;
      end
    end
  end

  task automatic expect_val(input string nm, input int sel, input int exp);
    sb_q.push_back('{nm, sel, 32'(exp)});
    pending++;
    ->chk_ev;
    wait (pending == 0);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic count_hi(input bit slow);
    hi_cnt = 0;
    repeat (16) begin
      step(1);
      hi_cnt += slow ? int'(pwm_s) : int'(pwm_out);
    end
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timed out");
  end

  initial begin : stimulus
    // Reset held: inputs wiggle, outputs stay zero.
    for (int i = 0; i < 4; i++) begin
      led_in = i[0];
      enable = i[1];
      step(1);
      expect_val("rst_duty", SEL_DUTY, 0);
      expect_val("rst_fading", SEL_FADING, 0);
      expect_val("rst_pwm", SEL_PWM, 0);
    end
    rst = 1'b1; led_in = 1'b0; enable = 1'b1;
    step(2);

    // Fade up from 0: change edge E, first step at E+4, full at E+60.
    led_in = 1'b1;
    step(1);
    for (int k = 1; k <= 60; k++) begin
      step(1);
      if (k == 4) expect_val("up_first_step", SEL_DUTY, 1);
      if (k < 60) expect_val("up_fading", SEL_FADING, 1);
      else begin
        expect_val("up_full", SEL_DUTY, 15);
        expect_val("up_done_fading", SEL_FADING, 0);
      end
    end
    count_hi(0);
    expect_val("full_pwm_highs", SEL_HI, exp_hi(15));

    // Fade down to 7, then reverse upward.
    led_in = 1'b0;
    step(1);
    step(4);  expect_val("down_first", SEL_DUTY, 14);
    step(28); expect_val("down_at7", SEL_DUTY, 7);
    led_in = 1'b1;
    step(1);
    step(3);  expect_val("rev_up_hold", SEL_DUTY, 7);
    step(1);  expect_val("rev_up_step", SEL_DUTY, 8);
    step(4);  expect_val("rev_up_9", SEL_DUTY, 9);

    // Enable drop at duty 9, then re-enable with target high.
    enable = 1'b0;
    step(1);
    expect_val("dis_duty", SEL_DUTY, 0);
    expect_val("dis_pwm", SEL_PWM, 0);
    expect_val("dis_fading", SEL_FADING, 0);
    step(3);  expect_val("dis_hold", SEL_DUTY, 0);
    enable = 1'b1;
    step(3);  expect_val("reen_wait", SEL_DUTY, 0);
    step(1);  expect_val("reen_first", SEL_DUTY, 1);
    step(24); expect_val("reen_at7", SEL_DUTY, 7);

    // Reversal downward at 7: no jump, one step per 4 edges.
    led_in = 1'b0;
    step(1);
    step(3);  expect_val("rev_dn_hold", SEL_DUTY, 7);
    step(1);  expect_val("rev_dn_6", SEL_DUTY, 6);
    step(4);  expect_val("rev_dn_5", SEL_DUTY, 5);

    // Change lands on the tick edge: change wins, step slips by 4 edges.
    step(3);
    led_in = 1'b1;
    step(1);  expect_val("coll_no_step", SEL_DUTY, 5);
    step(3);  expect_val("coll_wait", SEL_DUTY, 5);
    step(1);  expect_val("coll_next", SEL_DUTY, 6);

    // Asynchronous reset mid-ramp, between edges.
    step(2);
    rst = 1'b0;
    #2;
    expect_val("async_duty", SEL_DUTY, 0);
    expect_val("async_fading", SEL_FADING, 0);
    expect_val("async_pwm", SEL_PWM, 0);
    step(2);
    rst = 1'b1;
    step(1);  expect_val("post_rst_0", SEL_DUTY, 0);
    step(2);  expect_val("post_rst_1", SEL_DUTY, 0);

    // PWM high count per 16-cycle window on the slow instance.
    enable_s = 1'b1; led_in_s = 1'b1;
    step(1);
    step(1000); expect_val("slow_d1", SEL_DUTY_S, 1);
    step(1);    count_hi(1); expect_val("pwm_highs_d1", SEL_HI, exp_hi(1));
    step(3983); expect_val("slow_d5", SEL_DUTY_S, 5);
    step(1);    count_hi(1); expect_val("pwm_highs_d5", SEL_HI, exp_hi(5));
    step(2983); expect_val("slow_d8", SEL_DUTY_S, 8);
    step(1);    count_hi(1); expect_val("pwm_highs_d8", SEL_HI, exp_hi(8));

    step(1);
    if (sb_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain: got %0d expected 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
